// File: rtl/d_cache_2way_if.sv
// Bundles the two sides of the data cache into one interface.
//   p_*  CPU memory-stage request/response (CPU drives p_a, p_dout, p_strobe,
//        p_wen, p_size, p_rw; the cache returns p_din, p_ready).
//   m_*  memory bus (the cache drives m_a, m_din, m_strobe, m_wen, m_size,
//        m_rw; memory returns m_dout, m_ready).
// Modports:
//   master  the cache itself; it answers the CPU and masters the bus.
//   slave   the environment, meaning the CPU plus the memory behind the bus.
interface d_cache_2way_if #(
  parameter int unsigned A_WIDTH = 32
);
  logic [A_WIDTH-1:0] p_a;
  logic [31:0]        p_dout;
  logic [31:0]        p_din;
  logic               p_strobe;
  logic [3:0]         p_wen;
  logic [1:0]         p_size;
  logic               p_rw;
  logic               p_ready;

  logic [A_WIDTH-1:0] m_a;
  logic [31:0]        m_dout;
  logic [31:0]        m_din;
  logic               m_strobe;
  logic [3:0]         m_wen;
  logic [1:0]         m_size;
  logic               m_rw;
  logic               m_ready;

  modport master (
    input  p_a, p_dout, p_strobe, p_wen, p_size, p_rw,
    output p_din, p_ready,
    output m_a, m_din, m_strobe, m_wen, m_size, m_rw,
    input  m_dout, m_ready
  );

  modport slave (
    output p_a, p_dout, p_strobe, p_wen, p_size, p_rw,
    input  p_din, p_ready,
    input  m_a, m_din, m_strobe, m_wen, m_size, m_rw,
    output m_dout, m_ready
  );
endinterface

// File: rtl/d_cache_2way.sv
// Two-way set-associative, write-back, write-allocate data cache with
// multi-word lines and one LRU bit per set.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   cif  d_cache_2way_if.master: p_* CPU side, m_* memory bus side
// Hits complete combinationally in the request cycle. Misses optionally write
// back the dirty victim (WB) and then refill the whole line (RF); the request
// then hits on the cycle after the last refill beat. Addresses in
// 0xA000_0000-0xBFFF_FFFF bypass the cache through a combinational passthrough
// that only operates while the controller is idle.
module d_cache_2way #(
  parameter int unsigned A_WIDTH  = 32,
  parameter int unsigned C_INDEX  = 6,
  parameter int unsigned L_OFFSET = 2
) (
  input  logic          clk,
  input  logic          rst,
  d_cache_2way_if.master cif
);

  localparam int unsigned LW      = 1 << L_OFFSET;
  localparam int unsigned SETS    = 1 << C_INDEX;
  localparam int unsigned T_WIDTH = A_WIDTH - C_INDEX - L_OFFSET - 2;
  localparam int unsigned CW      = (L_OFFSET == 0) ? 1 : L_OFFSET;
  localparam int unsigned DW      = C_INDEX + L_OFFSET;

  typedef enum logic [1:0] {IDLE, WB, RF} state_t;

  // Storage: per way valid/dirty/tag per set, line words flattened as {set, word}
  logic [31:0]        data_q  [2][SETS*LW];
  logic [T_WIDTH-1:0] tag_q   [2][SETS];
  logic [SETS-1:0]    valid_q [2];
  logic [SETS-1:0]    dirty_q [2];
  logic [SETS-1:0]    lru_q;

  // Miss context, captured so the burst survives p_strobe dropping
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               way_q;
  logic [T_WIDTH-1:0] rtag_q;
  logic [C_INDEX-1:0] rset_q;

  logic [T_WIDTH-1:0] p_tag;
  logic [C_INDEX-1:0] p_set;
  logic [CW-1:0]      p_word;
  logic [DW-1:0]      p_idx;
  logic [DW-1:0]      r_idx;
  logic               uncached;
  logic               hit0;
  logic               hit1;
  logic               lookup;
  logic               hit;
  logic               miss;
  logic               hit_way;
  logic               victim;
  logic               last;

  function automatic logic [DW-1:0] data_index(input logic [C_INDEX-1:0] s,
                                               input logic [CW-1:0] w);
    return (DW'(s) << L_OFFSET) | DW'(w);
  endfunction

  function automatic logic [A_WIDTH-1:0] line_addr(input logic [T_WIDTH-1:0] t,
                                                   input logic [C_INDEX-1:0] s,
                                                   input logic [CW-1:0] w);
    return (A_WIDTH'(t) << (C_INDEX + L_OFFSET + 2)) |
           (A_WIDTH'(s) << (L_OFFSET + 2)) |
           (A_WIDTH'(w) << 2);
  endfunction

  // Address decode and tag compare
  assign p_tag    = cif.p_a[A_WIDTH-1 -: T_WIDTH];
  assign p_set    = cif.p_a[L_OFFSET+2 +: C_INDEX];
  assign p_word   = CW'(cif.p_a >> 2) & CW'(LW - 1);
  assign p_idx    = data_index(p_set, p_word);
  assign r_idx    = data_index(rset_q, cnt_q);
  assign uncached = (cif.p_a[A_WIDTH-1 -: 3] == 3'b101);
  assign hit0     = valid_q[0][p_set] && (tag_q[0][p_set] == p_tag);
  assign hit1     = valid_q[1][p_set] && (tag_q[1][p_set] == p_tag);
  assign lookup   = (state_q == IDLE) && cif.p_strobe && !uncached;
  assign hit      = lookup && (hit0 || hit1);
  assign miss     = lookup && !hit0 && !hit1;
  assign hit_way  = !hit0;
  assign last     = (cnt_q == CW'(LW - 1));

  // Fill invalid ways first (way 0 preferred), otherwise evict the LRU way
  assign victim = !valid_q[0][p_set] ? 1'b0 :
                  !valid_q[1][p_set] ? 1'b1 : lru_q[p_set];

  // CPU response and bus request; reset masks both handshakes
  always_comb begin
    cif.p_din    = '0;
    cif.p_ready  = 1'b0;
    cif.m_a      = '0;
    cif.m_din    = '0;
    cif.m_strobe = 1'b0;
    cif.m_wen    = '0;
    cif.m_size   = '0;
    cif.m_rw     = 1'b0;
    case (state_q)
      IDLE: begin
        if (uncached) begin
          cif.m_a      = {3'b000, cif.p_a[A_WIDTH-4:0]};
          cif.m_din    = cif.p_dout;
          cif.m_strobe = cif.p_strobe;
          cif.m_wen    = cif.p_wen;
          cif.m_size   = cif.p_size;
          cif.m_rw     = cif.p_rw;
          cif.p_din    = cif.m_dout;
          cif.p_ready  = cif.p_strobe && cif.m_ready;
        end else if (hit) begin
          cif.p_din   = data_q[hit_way][p_idx];
          cif.p_ready = 1'b1;
        end
      end
      WB: begin
        cif.m_a      = line_addr(tag_q[way_q][rset_q], rset_q, cnt_q);
        cif.m_din    = data_q[way_q][r_idx];
        cif.m_strobe = 1'b1;
        cif.m_wen    = 4'b1111;
        cif.m_size   = 2'b10;
        cif.m_rw     = 1'b1;
      end
      RF: begin
        cif.m_a      = line_addr(rtag_q, rset_q, cnt_q);
        cif.m_strobe = 1'b1;
        cif.m_wen    = 4'b1111;
        cif.m_size   = 2'b10;
      end
      default: ;
    endcase
    if (rst) begin
      cif.m_strobe = 1'b0;
      cif.p_ready  = 1'b0;
    end
  end

  // Controller state, array updates and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            lru_q[p_set] <= ~hit_way;
            if (cif.p_rw) begin
              dirty_q[hit_way][p_set] <= 1'b1;
              for (int b = 0; b < 4; b++) begin
                if (cif.p_wen[b]) data_q[hit_way][p_idx][8*b +: 8] <= cif.p_dout[8*b +: 8];
              end
            end
          end else if (miss) begin
            way_q   <= victim;
            rtag_q  <= p_tag;
            rset_q  <= p_set;
            cnt_q   <= '0;
            state_q <= (valid_q[victim][p_set] && dirty_q[victim][p_set]) ? WB : RF;
          end
        end
        WB: begin
          if (cif.m_ready) begin
            cnt_q <= last ? '0 : cnt_q + CW'(1);
            if (last) state_q <= RF;
          end
        end
        RF: begin
          if (cif.m_ready) begin
            data_q[way_q][r_idx] <= cif.m_dout;
            cnt_q <= last ? '0 : cnt_q + CW'(1);
            if (last) begin
              valid_q[way_q][rset_q] <= 1'b1;
              dirty_q[way_q][rset_q] <= 1'b0;
              tag_q[way_q][rset_q]   <= rtag_q;
              state_q                <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_2way.sv
// Scoreboard bench for d_cache_2way (LW=4, 64 sets). The stimulus pushes the
// expected CPU responses and bus beats into queues; a negedge monitor pops
// and compares them whenever p_ready or an m_* handshake appears. A
// behavioural memory answers the bus with a programmable stall count.
module tb_d_cache_2way;

  typedef struct {
    logic [31:0] a;
    logic        rw;
    logic [31:0] din;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  d_cache_2way_if #(.A_WIDTH(32)) cif();

  d_cache_2way #(.A_WIDTH(32), .C_INDEX(6), .L_OFFSET(2)) dut (
    .clk (clk),
    .rst (rst),
    .cif (cif)
  );

  int          checks = 0;
  int          fails  = 0;
  beat_t       exp_m[$];
  logic [31:0] exp_p[$];
  logic [31:0] mem [int unsigned];
  int          stall   = 0;
  int          wcnt    = 0;
  bit          bus_chk = 1'b1;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory: answers a strobe after `stall` idle cycles, driven just after the edge
  initial begin
    cif.m_ready = 1'b0;
    cif.m_dout  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (cif.m_strobe) begin
        if (wcnt >= stall) begin
          cif.m_ready = 1'b1;
          cif.m_dout  = rd(cif.m_a);
          wcnt        = 0;
        end else begin
          cif.m_ready = 1'b0;
          wcnt++;
        end
      end else begin
        cif.m_ready = 1'b0;
        wcnt        = 0;
      end
    end
  end

  // Monitor: CPU responses, bus beats, and address stability while stalled
  initial begin
    forever begin
      @(negedge clk);
      if (cif.p_ready) begin
        if (exp_p.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL p_resp: unexpected p_ready with p_din %h, none required", cif.p_din);
        end else begin
          check("p_din", cif.p_din, exp_p.pop_front());
        end
      end
      if (cif.m_strobe && cif.m_ready) begin
        if (cif.m_rw) mem[cif.m_a] = cif.m_din;
        if (bus_chk) begin
          if (exp_m.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL bus_beat: unexpected beat at %h rw %0b, none required", cif.m_a, cif.m_rw);
          end else begin
            beat_t e;
            e = exp_m.pop_front();
            check("m_a", cif.m_a, e.a);
            check("m_rw", 32'(cif.m_rw), 32'(e.rw));
            if (e.rw) check("m_din", cif.m_din, e.din);
          end
        end
      end
      if (prev_wait && cif.m_strobe) check("m_a_hold", cif.m_a, prev_a);
      prev_wait = cif.m_strobe && !cif.m_ready;
      prev_a    = cif.m_a;
    end
  end

  task automatic exp_rf(input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.a = base + 32'(4 * i); b.rw = 1'b0; b.din = '0;
      exp_m.push_back(b);
    end
  endtask

  task automatic exp_wb(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    beat_t b;
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      b.a = base + 32'(4 * i); b.rw = 1'b1; b.din = d[i];
      exp_m.push_back(b);
    end
  endtask

  task automatic cpu_req(input string name, input logic [31:0] a, input logic rw,
                         input logic [3:0] wen, input logic [31:0] d,
                         input logic [31:0] exp_d, input int exp_lat);
    int lat = 0;
    @(posedge clk);
    #1;
    cif.p_a = a; cif.p_rw = rw; cif.p_wen = wen; cif.p_dout = d;
    cif.p_size = 2'b10; cif.p_strobe = 1'b1;
    exp_p.push_back(exp_d);
    @(negedge clk);
    while (!cif.p_ready && lat < 300) begin
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    cif.p_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      mem[32'h40   + 32'(4*i)] = 32'h11 * 32'(i + 1);
      mem[32'h440  + 32'(4*i)] = 32'h55 + 32'h11 * 32'(i);
      mem[32'h840  + 32'(4*i)] = 32'h99 + 32'h11 * 32'(i);
      mem[32'hC40  + 32'(4*i)] = 32'h0C0C_0001 + 32'(i);
      mem[32'h10   + 32'(4*i)] = 32'hD0D0_D0D0 + 32'(i);
      mem[32'h2020 + 32'(4*i)] = 32'h2020_0000 | 32'(4*i);
      mem[32'h2420 + 32'(4*i)] = 32'h2420_0000 | 32'(4*i);
    end

    // Reset with an uncached request pending: both handshakes must stay low
    rst = 1'b1;
    cif.p_a = 32'hA000_0010; cif.p_dout = '0; cif.p_wen = '0;
    cif.p_size = 2'b10; cif.p_rw = 1'b0; cif.p_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_strobe", 32'(cif.m_strobe), 32'd0);
    check("rst_p_ready", 32'(cif.p_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cif.p_strobe = 1'b0;

    // Cold load fills way 0, then a hit on another word of the line
    exp_rf(32'h40);
    cpu_req("ld_40", 32'h40, 1'b0, 4'b0000, '0, 32'h11, 5);
    cpu_req("ld_4c", 32'h4C, 1'b0, 4'b0000, '0, 32'h44, 0);

    // Byte store hit, then read back the merged word
    cpu_req("st_44", 32'h44, 1'b1, 4'b0010, 32'h0000_AB00, 32'h22, 0);
    cpu_req("ld_44", 32'h44, 1'b0, 4'b0000, '0, 32'h0000_AB22, 0);

    // Second tag in set 4 fills way 1; first tag still resident
    exp_rf(32'h440);
    cpu_req("ld_440", 32'h440, 1'b0, 4'b0000, '0, 32'h55, 5);
    cpu_req("ld_48", 32'h48, 1'b0, 4'b0000, '0, 32'h33, 0);

    // Third tag evicts LRU way 1 (clean), fourth evicts dirty way 0
    exp_rf(32'h840);
    cpu_req("ld_840", 32'h840, 1'b0, 4'b0000, '0, 32'h99, 5);
    exp_wb(32'h40, 32'h11, 32'h0000_AB22, 32'h33, 32'h44);
    exp_rf(32'hC40);
    cpu_req("ld_c40", 32'hC40, 1'b0, 4'b0000, '0, 32'h0C0C_0001, 9);

    // Refetching the written-back line returns the stored byte
    exp_rf(32'h40);
    cpu_req("ld_44_again", 32'h44, 1'b0, 4'b0000, '0, 32'h0000_AB22, 5);

    // Uncached load passes straight through and leaves the cache untouched
    begin
      beat_t b;
      b.a = 32'h10; b.rw = 1'b0; b.din = '0;
      exp_m.push_back(b);
    end
    cpu_req("ld_uc", 32'hA000_0010, 1'b0, 4'b0000, '0, 32'hD0D0_D0D0, 0);
    exp_rf(32'h10);
    cpu_req("ld_10", 32'h10, 1'b0, 4'b0000, '0, 32'hD0D0_D0D0, 5);

    // Refill with 3 stall cycles per beat
    stall = 3;
    exp_rf(32'h2020);
    cpu_req("ld_2028_stall", 32'h2028, 1'b0, 4'b0000, '0, 32'h2020_0008, 17);
    stall = 0;

    // Dirty line in set 2 way 0, fill way 1, then reset during write-back
    cpu_req("st_2024", 32'h2024, 1'b1, 4'b1111, 32'h1234_5678, 32'h2020_0004, 0);
    exp_rf(32'h2420);
    cpu_req("ld_2420", 32'h2420, 1'b0, 4'b0000, '0, 32'h2420_0000, 5);

    bus_chk = 1'b0;
    @(posedge clk);
    #1;
    cif.p_a = 32'h2820; cif.p_rw = 1'b0; cif.p_wen = '0; cif.p_strobe = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(cif.m_strobe && cif.m_rw) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("wb_started", 32'(cif.m_strobe && cif.m_rw), 32'd1);
    check("wb_first_a", cif.m_a, 32'h2020);
    check("wb_first_din", cif.m_din, 32'h2020_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cif.p_strobe = 1'b0;
    @(negedge clk);
    check("rst_wb_m_strobe", 32'(cif.m_strobe), 32'd0);
    check("rst_wb_p_ready", 32'(cif.p_ready), 32'd0);
    @(negedge clk);
    check("rst_wb_m_strobe2", 32'(cif.m_strobe), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_chk = 1'b1;

    // After reset the previously resident line misses and the lost store is gone
    exp_rf(32'h2020);
    cpu_req("ld_2028_post_rst", 32'h2028, 1'b0, 4'b0000, '0, 32'h2020_0008, 5);
    cpu_req("ld_2024_post_rst", 32'h2024, 1'b0, 4'b0000, '0, 32'h2020_0004, 0);

    repeat (2) @(negedge clk);
    check("exp_p_drained", 32'(exp_p.size()), 32'd0);
    check("exp_m_drained", 32'(exp_m.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
